serial_adder_ctrl: RTL and testbench

Bit-serial adder controller. It adds two WIDTH-bit operands one bit per clock, using a single 1-bit full-adder cell. The cell is built from two half_adder instances plus an OR gate for carry.
- Sequences operand shifting, carry storage and result assembly.
- Uses a start/busy/done handshake.
- Sits between the lab's operand switches/registers and the result display logic.

---
 rtl/serial_adder_ctrl.sv | 102 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder controller, one operand bit per clock through a half-adder-built full adder
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sr_q, sr_d, sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d, cout_q, cout_d;
    logic             h0_s, h0_c, fa_s, h1_c, fa_c;

    half_adder u_ha0 (.x(a_q[0]), .y(b_q[0]), .s(h0_s), .c(h0_c));
    half_adder u_ha1 (.x(h0_s),   .y(carry_q), .s(fa_s), .c(h1_c));
    assign fa_c = h0_c | h1_c;

    // Next-state: capture on start, shift one bit per RUN cycle, publish result only on RUN->DONE
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        if (state_q == IDLE) begin
            if (start) begin
                state_d = RUN;
                a_d     = a;
                b_d     = b;
                sr_d    = '0;
                cnt_d   = '0;
                carry_d = 1'b0;
            end
        end else if (state_q == RUN) begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            sr_d    = {fa_s, sr_q[WIDTH-1:1]};
            carry_d = fa_c;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
                state_d = DONE;
                sum_d   = {fa_s, sr_q[WIDTH-1:1]};
                cout_d  = fa_c;
            end
        end else begin
            state_d = IDLE;
        end
    end

    // State registers with synchronous reset that also discards any in-flight add
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sr_q    <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed vector bench for serial_adder_ctrl at WIDTH=8 and WIDTH=4
module tb_serial_adder_ctrl;
    logic       clk = 1'b0;
    logic       rst, start, rst4, start4;
    logic [7:0] a, b, sum;
    logic [3:0] a4, b4, sum4;
    logic       busy, done, cout, busy4, done4, cout4;
    logic [7:0] hold_s;
    logic       hold_c;
    int         n_cmp = 0, n_err = 0;

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic [7:0] es;
        logic       ec;
    } vec_t;
    vec_t vecs[6];

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );
    serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst4), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic add8(input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] es, input logic ec);
        int nb, lat;
        @(negedge clk);
        a = ia; b = ib; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; a = ~ia; b = ~ib;
        nb = 0; lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (busy) nb++;
            if (!done) chk("sum_held_run", {23'd0, cout, sum}, {23'd0, hold_c, hold_s});
        end while (!done && lat < 20);
        chk("done_latency", lat, 9);
        chk("busy_cycles", nb, 8);
        chk("sum", {24'd0, sum}, {24'd0, es});
        chk("cout", {31'd0, cout}, {31'd0, ec});
        hold_s = es; hold_c = ec;
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 0);
        chk("busy_after_done", {31'd0, busy}, 0);
    endtask

    task automatic add4(input logic [3:0] ia, input logic [3:0] ib, output int nb);
        int lat;
        logic [4:0] ref5;
        ref5 = {1'b0, ia} + {1'b0, ib};
        @(negedge clk);
        a4 = ia; b4 = ib; start4 = 1'b1;
        @(posedge clk);
        #1 start4 = 1'b0;
        nb = 0; lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (busy4) nb++;
        end while (!done4 && lat < 12);
        chk("w4_done_latency", lat, 5);
        chk("w4_sum_cout", {27'd0, cout4, sum4}, {27'd0, ref5});
    endtask

    initial begin
        int nb, nd, t1, t2, lat;
        logic [7:0] s1, s2;
        vecs[0] = '{8'h3C, 8'h0F, 8'h4B, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0};
        vecs[4] = '{8'hAA, 8'h55, 8'hFF, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 8'h00, 1'b1};
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        rst4 = 1'b1; start4 = 1'b0; a4 = '0; b4 = '0;
        hold_s = '0; hold_c = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; rst4 = 1'b0;
        @(negedge clk);
        chk("reset_state", {20'd0, busy, done, cout, sum, busy4}, 0);
        chk("reset_state_w4", {26'd0, done4, cout4, sum4}, 0);

        for (int i = 0; i < 6; i++) begin
            add8(vecs[i].va, vecs[i].vb, vecs[i].es, vecs[i].ec);
            if (i == 0)
                for (int j = 0; j < 5; j++) begin
                    @(negedge clk);
                    chk("idle_hold", {22'd0, busy, done, sum}, {24'd0, 8'h4B});
                end
        end

        // Start pulsed again mid-RUN with new operands must be ignored
        @(negedge clk);
        a = 8'h12; b = 8'h34; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        nb = 0; nd = 0; s1 = '0;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) begin nd++; s1 = sum; end
            if (j == 3) begin start = 1'b1; a = 8'hFF; b = 8'hFF; end
            if (j == 4) begin start = 1'b0; a = 8'h55; b = 8'hAA; end
        end
        chk("midrun_done_count", nd, 1);
        chk("midrun_busy_cycles", nb, 8);
        chk("midrun_sum", {24'd0, s1}, 32'h46);
        chk("midrun_cout", {31'd0, cout}, 0);
        hold_s = 8'h46; hold_c = 1'b0;

        // Reset in the 4th RUN cycle discards the operation
        @(negedge clk);
        a = 8'h80; b = 8'h80; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_midrun_outputs", {22'd0, busy, done, cout, sum}, 0);
        nd = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        chk("rst_midrun_no_done", nd, 0);
        hold_s = '0; hold_c = 1'b0;
        add8(8'h80, 8'h80, 8'h00, 1'b1);

        // Reset coinciding with the done cycle clears outputs
        @(negedge clk);
        a = 8'h3C; b = 8'h0F; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!done && lat < 20);
        chk("rst_done_seen", {31'd0, done}, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_on_done_outputs", {22'd0, busy, done, cout, sum}, 0);
        hold_s = '0; hold_c = 1'b0;

        // start held high: back-to-back operations every WIDTH+2 cycles
        @(negedge clk);
        a = 8'h01; b = 8'h02; start = 1'b1;
        nd = 0; t1 = 0; t2 = 0; s1 = '0; s2 = '0;
        for (int j = 1; j <= 40 && nd < 2; j++) begin
            @(negedge clk);
            if (j == 1) begin a = 8'h10; b = 8'h20; end
            if (done) begin
                nd++;
                if (nd == 1) begin t1 = j; s1 = sum; end
                else begin t2 = j; s2 = sum; start = 1'b0; end
            end
        end
        start = 1'b0;
        chk("held_done_count", nd, 2);
        chk("held_spacing", t2 - t1, 10);
        chk("held_sum1", {24'd0, s1}, 32'h03);
        chk("held_sum2", {24'd0, s2}, 32'h30);
        repeat (12) @(negedge clk);
        chk("held_release_idle", {30'd0, busy, done}, 0);

        // WIDTH=4: corner case then exhaustive sweep
        add4(4'hF, 4'hF, nb);
        chk("w4_busy_cycles", nb, 4);
        chk("w4_ff_sum", {27'd0, cout4, sum4}, 32'h1E);
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                add4(4'(x), 4'(y), nb);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
